// File: rtl/systolic_pe_column_pkg.sv
// systolic_pe_column_pkg: PE mode enum and width helpers shared by the column and its PEs.
package systolic_pe_column_pkg;
  typedef enum logic {MULT, FMA} pe_mode_e;
  function automatic int pe_out_w(input int act_w, input int wgt_w, input int n);
    return act_w + wgt_w + $clog2(n);
  endfunction
  function automatic int acc_pad_w(input int from_w, input int acc_w);
    return acc_w - from_w;
  endfunction
endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: registered signed multiply (MULT) or multiply-add (FMA) processing element.
module systolic_pe
  import systolic_pe_column_pkg::*;
#(
  parameter pe_mode_e MODE  = MULT,
  parameter int       A_W   = 16,
  parameter int       B_W   = 16,
  parameter int       OUT_W = 35
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  input  logic signed [OUT_W-1:0] c,
  output logic signed [OUT_W-1:0] out
);
  logic signed [A_W+B_W-1:0] w_prod;
  logic signed [OUT_W-1:0]   w_prod_x;
  logic signed [OUT_W-1:0]   w_c;
  assign w_prod   = a * b;
  assign w_prod_x = OUT_W'(w_prod);
  assign w_c      = (MODE == FMA) ? c : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) out <= '0;
    else       out <= w_prod_x + w_c;
endmodule

// File: rtl/systolic_pe_column.sv
// systolic_pe_column: one weight-stationary column; PE chain dot product into a bias/self accumulator.
// PE_COL_SKEW_EN: when defined, lanes are skewed internally; otherwise the caller pre-skews them.
module systolic_pe_column
  import systolic_pe_column_pkg::*;
#(
  parameter int ARRAY_N      = 8,
  parameter int ACT_WIDTH    = 16,
  parameter int WGT_WIDTH    = 16,
  parameter int BIAS_WIDTH   = 32,
  parameter int ACC_WIDTH    = 48,
  parameter int PE_OUT_WIDTH = pe_out_w(ACT_WIDTH, WGT_WIDTH, ARRAY_N)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic                          acc_clear,
  input  logic [ARRAY_N*ACT_WIDTH-1:0]  act_in,
  input  logic [ARRAY_N*WGT_WIDTH-1:0]  wgt_in,
  input  logic signed [BIAS_WIDTH-1:0]  bias_in,
  output logic [ACC_WIDTH-1:0]          acc_out,
  output logic                          out_valid
);
  logic signed [ACT_WIDTH-1:0]    w_a   [ARRAY_N];
  logic signed [WGT_WIDTH-1:0]    w_b   [ARRAY_N];
  logic signed [PE_OUT_WIDTH-1:0] w_cin [ARRAY_N];
  logic signed [PE_OUT_WIDTH-1:0] w_pe  [ARRAY_N];
  for (genvar n = 0; n < ARRAY_N; n++) begin : g_lane
`ifdef PE_COL_SKEW_EN
    if (n == 0) begin : g_direct
      assign w_a[n] = act_in[n*ACT_WIDTH +: ACT_WIDTH];
      assign w_b[n] = wgt_in[n*WGT_WIDTH +: WGT_WIDTH];
    end else begin : g_skew
      logic [ACT_WIDTH-1:0] r_a [n];
      logic [WGT_WIDTH-1:0] r_b [n];
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          r_a <= '{default: '0};
          r_b <= '{default: '0};
        end else begin
          r_a[0] <= act_in[n*ACT_WIDTH +: ACT_WIDTH];
          r_b[0] <= wgt_in[n*WGT_WIDTH +: WGT_WIDTH];
          for (int k = 1; k < n; k++) begin
            r_a[k] <= r_a[k-1];
            r_b[k] <= r_b[k-1];
          end
        end
      assign w_a[n] = r_a[n-1];
      assign w_b[n] = r_b[n-1];
    end
`else
    assign w_a[n] = act_in[n*ACT_WIDTH +: ACT_WIDTH];
    assign w_b[n] = wgt_in[n*WGT_WIDTH +: WGT_WIDTH];
`endif
    if (n == 0) begin : g_head
      assign w_cin[n] = '0;
    end else begin : g_chain
      assign w_cin[n] = w_pe[n-1];
    end
    systolic_pe #(
      .MODE  (n == 0 ? MULT : FMA),
      .A_W   (ACT_WIDTH),
      .B_W   (WGT_WIDTH),
      .OUT_W (PE_OUT_WIDTH)
    ) u_pe (
      .clk   (clk),
      .reset (reset),
      .a     (w_a[n]),
      .b     (w_b[n]),
      .c     (w_cin[n]),
      .out   (w_pe[n])
    );
  end
  // Sideband delay matches the PE chain so valid/clear meet the finished dot product.
  logic [ARRAY_N-1:0] r_vld, r_clr;
  logic               r_acc_vld;
  logic signed [ACC_WIDTH-1:0] w_dot_x, w_bias_x, w_base, w_sum;
  logic                        w_clear;
  assign w_dot_x  = ACC_WIDTH'(w_pe[ARRAY_N-1]);
  assign w_bias_x = ACC_WIDTH'(bias_in);
  assign w_clear  = r_clr[ARRAY_N-1] | ~r_acc_vld;
  assign w_base   = w_clear ? w_bias_x : acc_out;
  assign w_sum    = w_dot_x + w_base;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_vld     <= '0;
      r_clr     <= '0;
      r_acc_vld <= 1'b0;
      acc_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      r_vld     <= {r_vld[ARRAY_N-2:0], in_valid};
      r_clr     <= {r_clr[ARRAY_N-2:0], acc_clear};
      out_valid <= r_vld[ARRAY_N-1];
      if (r_vld[ARRAY_N-1]) begin
        acc_out   <= w_sum;
        r_acc_vld <= 1'b1;
      end
    end
endmodule

// File: tb/tb_systolic_pe_column.sv
// tb_systolic_pe_column: table-driven directed check of the column, plus reset/first-vector sequences.
module tb_systolic_pe_column;
  localparam int N  = 8;
  localparam int AW = 16;
  localparam int WW = 16;
  localparam int BW = 32;
  localparam int CW = 48;
`ifdef PE_COL_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif
  typedef struct {
    logic          vld;
    logic          clr;
    logic [N*AW-1:0] act;
    logic [N*WW-1:0] wgt;
    logic [BW-1:0] bias;
    logic          ov;
    logic [CW-1:0] acc;
  } vec_t;
  vec_t tv [10];
  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            acc_clear = 1'b0;
  logic [N*AW-1:0] act_in = '0;
  logic [N*WW-1:0] wgt_in = '0;
  logic [BW-1:0]   bias_in = '0;
  logic [CW-1:0]   acc_out;
  logic            out_valid;
  int checks = 0;
  int failures = 0;
  systolic_pe_column dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .acc_clear (acc_clear),
    .act_in    (act_in),
    .wgt_in    (wgt_in),
    .bias_in   (bias_in),
    .acc_out   (acc_out),
    .out_valid (out_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [N*AW-1:0] lanes(input int base, input int step);
    logic [N*AW-1:0] v;
    v = '0;
    for (int n = 0; n < N; n++) v[n*AW +: AW] = AW'(base + step * n);
    return v;
  endfunction
  task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask
  // Drives the inputs for relative cycle e of the sequence tv[off +: cnt], pre-skewing lanes when needed.
  task automatic drive(input int e, input int off, input int cnt);
    int r;
    in_valid  = 1'b0;
    acc_clear = 1'b0;
    bias_in   = '0;
    act_in    = '0;
    wgt_in    = '0;
    if (e < cnt) begin
      in_valid  = tv[off+e].vld;
      acc_clear = tv[off+e].clr;
    end
    r = e - N;
    if (r >= 0 && r < cnt) bias_in = tv[off+r].bias;
    for (int n = 0; n < N; n++) begin
      r = SKEW ? e : e - n;
      if (r >= 0 && r < cnt) begin
        act_in[n*AW +: AW] = tv[off+r].act[n*AW +: AW];
        wgt_in[n*WW +: WW] = tv[off+r].wgt[n*WW +: WW];
      end
    end
  endtask
  task automatic run(input int off, input int cnt, input string tag);
    for (int e = 0; e < cnt + N; e++) begin
      drive(e, off, cnt);
      @(posedge clk);
      #1;
      if (e >= N) begin
        chk($sformatf("%s%0d_valid", tag, e - N), {47'd0, out_valid}, {47'd0, tv[off+e-N].ov});
        chk($sformatf("%s%0d_acc", tag, e - N), acc_out, tv[off+e-N].acc);
      end
    end
    drive(cnt + N, off, cnt);
  endtask
  initial begin
    tv[0] = '{1'b1, 1'b1, lanes(1, 1),      lanes(1, 0),      32'h0,         1'b1, 48'd36};
    tv[1] = '{1'b1, 1'b0, lanes(2, 0),      lanes(3, 0),      32'h0,         1'b1, 48'd84};
    tv[2] = '{1'b0, 1'b1, lanes(5, 0),      lanes(5, 0),      32'h100,       1'b0, 48'd84};
    tv[3] = '{1'b1, 1'b1, lanes(-1, 0),     lanes(2, 0),      32'hFFFF_FFFB, 1'b1, 48'hFFFF_FFFF_FFEB};
    tv[4] = '{1'b1, 1'b1, lanes(-32768, 0), lanes(-32768, 0), 32'h0,         1'b1, 48'h2_0000_0000};
    tv[5] = '{1'b1, 1'b0, lanes(-32768, 0), lanes(-32768, 0), 32'h1234,      1'b1, 48'h4_0000_0000};
    tv[6] = '{1'b1, 1'b1, lanes(32767, 0),  lanes(-32768, 0), 32'h7FFF_FFFF, 1'b1, 48'hFFFE_8003_FFFF};
    tv[7] = '{1'b1, 1'b1, lanes(1, 1),      lanes(0, 0),      32'd7,         1'b1, 48'h708};
    for (int n = 0; n < N; n++) tv[7].wgt[n*WW +: WW] = WW'(1 << n);
    tv[8] = '{1'b1, 1'b1, lanes(1, 1),      lanes(1, 0),      32'h0,         1'b1, 48'd36};
    tv[9] = '{1'b1, 1'b0, lanes(2, 0),      lanes(3, 0),      32'd10,        1'b1, 48'd58};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_acc", acc_out, '0);
    chk("reset_valid", {47'd0, out_valid}, '0);
    reset = 1'b0;
    run(0, 8, "vec");
    for (int e = 0; e < 3; e++) begin
      drive(e, 8, 1);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    chk("midreset_acc", acc_out, '0);
    chk("midreset_valid", {47'd0, out_valid}, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < N + 3; k++) begin
      drive(100, 8, 1);
      @(posedge clk);
      #1;
      chk($sformatf("dropped_%0d_valid", k), {47'd0, out_valid}, '0);
    end
    chk("dropped_acc", acc_out, '0);
    run(9, 1, "post_reset");
    @(posedge clk);
    #1;
    chk("post_reset_pulse_end", {47'd0, out_valid}, '0);
    chk("post_reset_hold", acc_out, 48'd58);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_pe_column.md
# systolic_pe_column

One column of the weight-stationary systolic array. It takes ARRAY_N activation/weight lanes and forms their signed dot product through a chain of registered multiply/FMA PEs. It then adds the result into a registered output accumulator that starts from either a bias or its own previous value. It sits between the input/weight buffer read ports and the output buffer write path, one instance per array column.

## Interface
Parameters:
- ARRAY_N, 8: number of PEs (lanes) in the column, ≥2.
- ACT_WIDTH, 16: signed activation width.
- WGT_WIDTH, 16: signed weight width.
- BIAS_WIDTH, 32: signed bias width.
- ACC_WIDTH, 48: accumulator width.
- PE_OUT_WIDTH, ACT_WIDTH+WGT_WIDTH+$clog2(ARRAY_N): partial-sum width.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: lane data valid this cycle.
- acc_clear, input, 1: qualified by in_valid; this vector starts a new sum from bias.
- act_in, input, ARRAY_N*ACT_WIDTH: lane n at [n*ACT_WIDTH +: ACT_WIDTH], signed.
- wgt_in, input, ARRAY_N*WGT_WIDTH: lane n at [n*WGT_WIDTH +: WGT_WIDTH], signed.
- bias_in, input, BIAS_WIDTH: signed bias, sampled on the accumulate cycle.
- acc_out, output, ACC_WIDTH: registered accumulator value.
- out_valid, output, 1: acc_out updated this cycle.

## Operation
- PE 0 is in MULT mode: out <= a*b.
- PE n≥1 is in FMA mode: out <= a*b + c. Here c is the out of PE n-1.
- All PE products and sums are signed and sign-extended to PE_OUT_WIDTH. This width cannot overflow for ARRAY_N terms.
- Lane n operands reach PE n exactly n cycles after lane 0, so PE ARRAY_N-1 emits the full dot product (see Configuration).
- in_valid and acc_clear travel through an ARRAY_N-stage sideband delay that is aligned with the column output.
- When the delayed valid is 1, the accumulator updates.
  - If the delayed clear is 1: acc_out <= sext(dot) + sext(bias_in).
  - Otherwise: acc_out <= sext(dot) + acc_out.
- When the delayed valid is 0, acc_out holds.
- Arithmetic is two's complement modulo 2^ACC_WIDTH; it wraps and does not saturate.
- After reset, the first valid vector is treated as cleared even if acc_clear=0.
  - A sticky "accumulator valid" flag holds this state. It is cleared by reset and set by the first accumulate.
- Vectors may arrive back-to-back, one per cycle, with no bubbles required.

## Timing
- Latency: in_valid at cycle t produces acc_out and out_valid=1 at cycle t+ARRAY_N+1.
- bias_in is sampled at cycle t+ARRAY_N, the edge that makes the update.
- Throughput: one vector per cycle.
- On reset, every register is 0: PE outputs, skew and sideband stages, acc_out, out_valid, and the accumulator-valid flag.
- Reset asserted mid-operation drops all in-flight vectors. No out_valid pulse appears for them after reset releases.
- in_valid=0 cycles propagate as bubbles. PEs still compute on whatever data is present, but those results are never accumulated.

## Configuration
- PE_COL_SKEW_EN defined: an internal register chain delays lane n of act_in and wgt_in by n cycles. The caller presents all lanes in the same cycle as in_valid.
- PE_COL_SKEW_EN undefined: there are no skew registers. The caller must present lane n n cycles after in_valid.
- Sideband timing and latency relative to in_valid are identical in both builds.

## Structure
- Shared package:
  - width helper constants/functions for PE_OUT_WIDTH and sign extension to ACC_WIDTH;
  - a PE mode enumeration (MULT, FMA).
- One natural sub-module, systolic_pe. It takes a mode parameter and has ports clk, reset, a, b, c and a registered out, and is instantiated ARRAY_N times.
- Skew, sideband delays and the accumulator stay inline.

## Test plan
- Dot product with bias: act=1..8, wgt=all 1, acc_clear=1, bias=0 → acc_out=36 at t+9 with out_valid=1 for exactly one cycle.
- Accumulate: the above vector, then the next cycle act=all 2, wgt=all 3, acc_clear=0 → outputs 36 then 84 on consecutive cycles.
- Signed values and bias: act=all -1, wgt=all 2, bias=-5, clear=1 → -21, which is 0xFFFF_FFFF_FFEB in 48 bits.
- Extremes: act=all -32768, wgt=all -32768 → 2^33 = 0x2_0000_0000, with no truncation in the PE chain.
- Reset: assert reset 3 cycles after in_valid → all outputs 0 and no later out_valid. Then the first post-reset vector with clear=0 loads bias.
- Build both with and without PE_COL_SKEW_EN, with lanes pre-skewed in the undefined build → identical acc_out sequences.
